// File: rtl/parity_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : parity_cmd_scheduler
// Purpose  : Schedules commands from the parity AFU read and write engines
//            onto the PSL command interface. The two requesters are served
//            round-robin. PSL tags come from a fixed pool, and PSL command
//            credits are tracked. Each response is retired back to the
//            requester that owns its tag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clock, reset           - clock; asynchronous active-high reset
//   job_start, room        - re-arm pulse; initial credit count
//   rd_*/wr_* req/addr/size - requester command inputs
//   rd_ack/wr_ack          - combinational grants
//   cmd_*                  - registered PSL command (valid/code/tag/addr/size)
//   rsp_*                  - PSL response (valid/tag/code/signed credits)
//   rd_done/wr_done        - completion pulses; done_tag/done_err qualify them
//   unexpected_rsp         - sticky flag for a response to a tag not outstanding
//   credits, idle          - credit count; no tags outstanding
// Optional feature (macro PARITY_SCHED_PARITY_EN): adds cmd_tag_par and
//   cmd_addr_par outputs, which carry odd parity of cmd_tag and cmd_addr.
// ============================================================================
module parity_cmd_scheduler #(
  parameter int         TAG_COUNT = 4,
  parameter logic [7:0] TAG_BASE  = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        job_start,
  input  logic [7:0]  room,
  input  logic        rd_req,
  input  logic [63:0] rd_addr,
  input  logic [11:0] rd_size,
  input  logic        wr_req,
  input  logic [63:0] wr_addr,
  input  logic [11:0] wr_size,
  output logic        rd_ack,
  output logic        wr_ack,
  output logic        cmd_valid,
  output logic [12:0] cmd_code,
  output logic [7:0]  cmd_tag,
  output logic [63:0] cmd_addr,
  output logic [11:0] cmd_size,
`ifdef PARITY_SCHED_PARITY_EN
  output logic        cmd_tag_par,
  output logic        cmd_addr_par,
`endif
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_tag,
  input  logic [7:0]  rsp_code,
  input  logic [8:0]  rsp_credits,
  output logic        rd_done,
  output logic        wr_done,
  output logic [7:0]  done_tag,
  output logic        done_err,
  output logic        unexpected_rsp,
  output logic [7:0]  credits,
  output logic        idle
);

  localparam int          c_IDXW       = (TAG_COUNT > 1) ? $clog2(TAG_COUNT) : 1;
  localparam logic [12:0] c_CODE_READ  = 13'h0A00;
  localparam logic [12:0] c_CODE_WRITE = 13'h0D00;
  localparam logic [7:0]  c_TAG_COUNT8 = 8'(TAG_COUNT);

  logic [TAG_COUNT-1:0] r_busy;
  logic [TAG_COUNT-1:0] r_owner_wr;
  logic                 r_last_wr;
  logic [7:0]           r_credits;

  logic [TAG_COUNT-1:0] w_busy_next;
  logic [TAG_COUNT-1:0] w_owner_next;
  logic [c_IDXW-1:0]    w_free_idx;
  logic [c_IDXW-1:0]    w_rsp_idx;
  logic [7:0]           w_rsp_off;
  logic                 w_has_free;
  logic                 w_can_grant;
  logic                 w_pick_wr;
  logic                 w_grant;
  logic                 w_rsp_hit;
  logic                 w_rsp_miss;
  logic [63:0]          w_sel_addr;
  logic [11:0]          w_sel_size;
  logic [7:0]           w_sel_tag;
  logic signed [10:0]   w_cred_sum;
  logic [7:0]           w_cred_next;

  // Lowest-index free tag. The search uses only the registered bitmap, so a
  // tag retired this cycle cannot be reissued until the next cycle.
  always_comb begin
    w_free_idx = '0;
    for (int i = TAG_COUNT - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = c_IDXW'(i);
    end
  end

  assign w_has_free  = ~&r_busy;
  assign w_can_grant = !job_start && (r_credits != 8'd0) && w_has_free;
  // On a tie, the requester that was not granted last wins.
  assign w_pick_wr   = wr_req && (!rd_req || !r_last_wr);
  assign rd_ack      = w_can_grant && rd_req && !w_pick_wr;
  assign wr_ack      = w_can_grant && w_pick_wr;
  assign w_grant     = rd_ack || wr_ack;

  assign w_sel_addr  = w_pick_wr ? wr_addr : rd_addr;
  assign w_sel_size  = w_pick_wr ? wr_size : rd_size;
  assign w_sel_tag   = TAG_BASE + 8'(w_free_idx);

  // Responses arriving during job_start are dropped entirely.
  assign w_rsp_off   = rsp_tag - TAG_BASE;
  assign w_rsp_idx   = w_rsp_off[c_IDXW-1:0];
  assign w_rsp_hit   = rsp_valid && !job_start && (w_rsp_off < c_TAG_COUNT8) && r_busy[w_rsp_idx];
  assign w_rsp_miss  = rsp_valid && !job_start && !w_rsp_hit;

  // The grant and the credit return are applied as one net change. The
  // range -257..510 fits in 11 signed bits before the result is clamped.
  always_comb begin
    w_cred_sum = $signed({3'b000, r_credits})
               - $signed({10'b0, w_grant})
               + (rsp_valid ? $signed({{2{rsp_credits[8]}}, rsp_credits}) : 11'sd0);
    if (w_cred_sum < 11'sd0)        w_cred_next = 8'd0;
    else if (w_cred_sum > 11'sd255) w_cred_next = 8'd255;
    else                            w_cred_next = w_cred_sum[7:0];
  end

  always_comb begin
    w_busy_next  = r_busy;
    w_owner_next = r_owner_wr;
    if (w_grant) begin
      w_busy_next[w_free_idx]  = 1'b1;
      w_owner_next[w_free_idx] = w_pick_wr;
    end
    if (w_rsp_hit) w_busy_next[w_rsp_idx] = 1'b0;
    if (job_start) begin
      w_busy_next  = '0;
      w_owner_next = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy         <= '0;
      r_owner_wr     <= '0;
      r_last_wr      <= 1'b1;
      r_credits      <= 8'd0;
      cmd_valid      <= 1'b0;
      cmd_code       <= '0;
      cmd_tag        <= '0;
      cmd_addr       <= '0;
      cmd_size       <= '0;
`ifdef PARITY_SCHED_PARITY_EN
      cmd_tag_par    <= 1'b1;
      cmd_addr_par   <= 1'b1;
`endif
      rd_done        <= 1'b0;
      wr_done        <= 1'b0;
      done_tag       <= '0;
      done_err       <= 1'b0;
      unexpected_rsp <= 1'b0;
    end else begin
      r_busy     <= w_busy_next;
      r_owner_wr <= w_owner_next;
      r_credits  <= job_start ? room : w_cred_next;
      cmd_valid  <= w_grant;
      if (w_grant) begin
        r_last_wr <= w_pick_wr;
        cmd_code  <= w_pick_wr ? c_CODE_WRITE : c_CODE_READ;
        cmd_tag   <= w_sel_tag;
        cmd_addr  <= w_sel_addr;
        cmd_size  <= w_sel_size;
`ifdef PARITY_SCHED_PARITY_EN
        cmd_tag_par  <= ~^w_sel_tag;
        cmd_addr_par <= ~^w_sel_addr;
`endif
      end
      rd_done <= w_rsp_hit && !r_owner_wr[w_rsp_idx];
      wr_done <= w_rsp_hit && r_owner_wr[w_rsp_idx];
      if (w_rsp_hit) begin
        done_tag <= rsp_tag;
        done_err <= (rsp_code != 8'd0);
      end
      if (job_start)       unexpected_rsp <= 1'b0;
      else if (w_rsp_miss) unexpected_rsp <= 1'b1;
    end
  end

  assign credits = r_credits;
  assign idle    = ~|r_busy;

endmodule
`default_nettype wire

// File: tb/tb_parity_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_cmd_scheduler
// Purpose  : Self-checking bench for parity_cmd_scheduler. A behavioural
//            model of tag pool, credits and arbitration is compared against
//            the DUT every cycle. Directed scenarios also pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_cmd_scheduler;
  localparam int         TAG_COUNT = 4;
  localparam logic [7:0] TAG_BASE  = 8'h00;

  logic        clock = 1'b0;
  logic        reset, job_start;
  logic [7:0]  room;
  logic        rd_req, wr_req;
  logic [63:0] rd_addr, wr_addr;
  logic [11:0] rd_size, wr_size;
  logic        rd_ack, wr_ack, cmd_valid;
  logic [12:0] cmd_code;
  logic [7:0]  cmd_tag;
  logic [63:0] cmd_addr;
  logic [11:0] cmd_size;
`ifdef PARITY_SCHED_PARITY_EN
  logic        cmd_tag_par, cmd_addr_par;
`endif
  logic        rsp_valid;
  logic [7:0]  rsp_tag, rsp_code;
  logic [8:0]  rsp_credits;
  logic        rd_done, wr_done, done_err, unexpected_rsp, idle;
  logic [7:0]  done_tag, credits;

  always #5 clock = ~clock;

  parity_cmd_scheduler #(.TAG_COUNT(TAG_COUNT), .TAG_BASE(TAG_BASE)) dut (
    .clock(clock), .reset(reset), .job_start(job_start), .room(room),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size),
    .rd_ack(rd_ack), .wr_ack(wr_ack),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_tag(cmd_tag),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size),
`ifdef PARITY_SCHED_PARITY_EN
    .cmd_tag_par(cmd_tag_par), .cmd_addr_par(cmd_addr_par),
`endif
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_code(rsp_code),
    .rsp_credits(rsp_credits),
    .rd_done(rd_done), .wr_done(wr_done), .done_tag(done_tag), .done_err(done_err),
    .unexpected_rsp(unexpected_rsp), .credits(credits), .idle(idle)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_out[TAG_COUNT];
  bit          m_own_wr[TAG_COUNT];
  bit          m_last_wr;
  int          m_credits;
  bit          m_unexp;
  bit          e_cmd_valid, e_rd_done, e_wr_done, e_done_err;
  logic [12:0] e_code;
  logic [7:0]  e_tag, e_done_tag;
  logic [63:0] e_addr;
  logic [11:0] e_size;
  logic [12:0] log_code[$];
  logic [7:0]  log_tag[$];

  always @(negedge clock) begin : p_compare
    int          free_idx, c, n_out;
    bit          can, pwr, g_rd, g_wr;
    logic [7:0]  off;
    if (reset) begin
      foreach (m_out[i]) begin m_out[i] = 0; m_own_wr[i] = 0; end
      m_last_wr = 1; m_credits = 0; m_unexp = 0;
      e_cmd_valid = 0; e_rd_done = 0; e_wr_done = 0; e_done_err = 0;
      e_code = '0; e_tag = '0; e_addr = '0; e_size = '0; e_done_tag = '0;
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_cmd_code",  cmd_code, 0);
      chk("rst_cmd_tag",   cmd_tag, 0);
      chk("rst_cmd_addr",  cmd_addr, 0);
      chk("rst_cmd_size",  cmd_size, 0);
      chk("rst_done",      {rd_done, wr_done, done_err}, 0);
      chk("rst_done_tag",  done_tag, 0);
      chk("rst_unexp",     unexpected_rsp, 0);
      chk("rst_credits",   credits, 0);
      chk("rst_idle",      idle, 1);
      chk("rst_acks",      {rd_ack, wr_ack}, 0);
`ifdef PARITY_SCHED_PARITY_EN
      chk("rst_par", {cmd_tag_par, cmd_addr_par}, 2'b11);
`endif
    end else begin
      // Registered outputs against the model's prediction.
      n_out = 0;
      foreach (m_out[i]) n_out += m_out[i];
      chk("cmd_valid", cmd_valid, e_cmd_valid);
      if (e_cmd_valid) begin
        chk("cmd_code", cmd_code, e_code);
        chk("cmd_tag",  cmd_tag,  e_tag);
        chk("cmd_addr", cmd_addr, e_addr);
        chk("cmd_size", cmd_size, e_size);
`ifdef PARITY_SCHED_PARITY_EN
        chk("cmd_tag_par",  cmd_tag_par,  ~^e_tag);
        chk("cmd_addr_par", cmd_addr_par, ~^e_addr);
`endif
      end
      if (cmd_valid) begin log_code.push_back(cmd_code); log_tag.push_back(cmd_tag); end
      chk("rd_done", rd_done, e_rd_done);
      chk("wr_done", wr_done, e_wr_done);
      if (e_rd_done || e_wr_done) begin
        chk("done_tag", done_tag, e_done_tag);
        chk("done_err", done_err, e_done_err);
      end
      chk("unexpected_rsp", unexpected_rsp, m_unexp);
      chk("credits", credits, m_credits[7:0]);
      chk("idle", idle, n_out == 0);

      // Grant prediction from the current inputs.
      free_idx = -1;
      for (int i = 0; i < TAG_COUNT; i++) if (!m_out[i] && free_idx < 0) free_idx = i;
      can  = !job_start && m_credits > 0 && free_idx >= 0;
      pwr  = (rd_req && wr_req) ? !m_last_wr : wr_req;
      g_wr = can && wr_req && pwr;
      g_rd = can && rd_req && !pwr;
      chk("rd_ack", rd_ack, g_rd);
      chk("wr_ack", wr_ack, g_wr);

      // Advance the model to the state after the coming clock edge.
      e_rd_done = 0; e_wr_done = 0;
      e_cmd_valid = g_rd || g_wr;
      if (job_start) begin
        m_credits = room; m_unexp = 0;
        foreach (m_out[i]) begin m_out[i] = 0; m_own_wr[i] = 0; end
      end else begin
        if (rsp_valid) begin
          off = rsp_tag - TAG_BASE;
          if (off < TAG_COUNT && m_out[off]) begin
            m_out[off] = 0;
            if (m_own_wr[off]) e_wr_done = 1; else e_rd_done = 1;
            e_done_tag = rsp_tag;
            e_done_err = (rsp_code != 0);
          end else begin
            m_unexp = 1;
          end
        end
        if (g_rd || g_wr) begin
          m_out[free_idx] = 1; m_own_wr[free_idx] = g_wr; m_last_wr = g_wr;
          e_code = g_wr ? 13'h0D00 : 13'h0A00;
          e_tag  = TAG_BASE + 8'(free_idx);
          e_addr = g_wr ? wr_addr : rd_addr;
          e_size = g_wr ? wr_size : rd_size;
        end
        c = m_credits - ((g_rd || g_wr) ? 1 : 0) + (rsp_valid ? int'($signed(rsp_credits)) : 0);
        m_credits = (c < 0) ? 0 : ((c > 255) ? 255 : c);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input bit wr, input int n);
    int got;
    got = 0;
    if (wr) wr_req = 1; else rd_req = 1;
    for (int k = 0; k < 20 && got < n; k++) begin
      #1;
      if (wr ? wr_ack : rd_ack) got++;
      tick();
    end
    wr_req = 0; rd_req = 0;
    chk("issue_count", got, n);
  endtask

  task automatic respond(input logic [7:0] tag, input logic [7:0] code, input logic [8:0] cr);
    rsp_valid = 1; rsp_tag = tag; rsp_code = code; rsp_credits = cr;
    tick();
    rsp_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1; job_start = 0; room = 0;
    rd_req = 0; wr_req = 0; rd_addr = 0; wr_addr = 0; rd_size = 0; wr_size = 0;
    rsp_valid = 0; rsp_tag = 0; rsp_code = 0; rsp_credits = 0;
    tick(); tick();
    reset = 0;
    tick();
    chk("lit_reset_credits", credits, 0);
    chk("lit_reset_idle", idle, 1);

    // Two read grants use up two credits.
    rd_addr = 64'h1000; rd_size = 12'd128;
    room = 8'd2; job_start = 1; tick(); job_start = 0;
    chk("lit_t1_credits_loaded", credits, 2);
    log_code.delete(); log_tag.delete();
    rd_req = 1;
    repeat (4) tick();
    #1;
    chk("lit_t1_rd_ack_blocked", rd_ack, 0);
    chk("lit_t1_credits", credits, 0);
    chk("lit_t1_ncmd", log_tag.size(), 2);
    if (log_tag.size() == 2) begin
      chk("lit_t1_tag0", log_tag[0], 8'd0);
      chk("lit_t1_tag1", log_tag[1], 8'd1);
      chk("lit_t1_code", {log_code[0], log_code[1]}, {13'h0A00, 13'h0A00});
    end
    rd_req = 0;

    // Round-robin from reset: rd, wr, rd, wr, then the pool is exhausted.
    reset = 1; tick(); reset = 0;
    wr_addr = 64'h2000; wr_size = 12'd64;
    room = 8'd8; job_start = 1; tick(); job_start = 0;
    log_code.delete(); log_tag.delete();
    rd_req = 1; wr_req = 1;
    repeat (6) tick();
    #1;
    chk("lit_t2_acks", {rd_ack, wr_ack}, 0);
    chk("lit_t2_idle", idle, 0);
    chk("lit_t2_credits", credits, 4);
    chk("lit_t2_ncmd", log_code.size(), 4);
    if (log_code.size() == 4) begin
      chk("lit_t2_order", {log_code[0], log_code[1], log_code[2], log_code[3]},
          {13'h0A00, 13'h0D00, 13'h0A00, 13'h0D00});
      chk("lit_t2_tags", {log_tag[0], log_tag[1], log_tag[2], log_tag[3]}, 32'h00010203);
    end
    rd_req = 0; wr_req = 0;

    // Retirement, net credit change and the one-cycle reuse delay.
    room = 8'd4; job_start = 1; tick(); job_start = 0;
    issue(0, 2);          // tags 0,1 owned by read
    issue(1, 1);          // tag 2 owned by write
    chk("lit_t3_credits_pre", credits, 1);
    wr_req = 1;
    rsp_valid = 1; rsp_tag = 8'd1; rsp_code = 8'd0; rsp_credits = 9'd1;
    #1;
    chk("lit_t3_wr_ack_with_rsp", wr_ack, 1);
    tick();
    rsp_valid = 0;
    chk("lit_t3_credits_net", credits, 1);
    chk("lit_t3_rd_done", {rd_done, wr_done}, 2'b10);
    chk("lit_t3_done_tag", done_tag, 1);
    chk("lit_t3_done_err", done_err, 0);
    chk("lit_t3_cmd_tag3", cmd_tag, 3);
    #1;
    chk("lit_t3_reuse_ack", wr_ack, 1);
    tick();
    wr_req = 0;
    chk("lit_t3_reused_tag", cmd_tag, 1);
    respond(8'd2, 8'h01, 9'd0);
    chk("lit_t3_wr_done", {rd_done, wr_done}, 2'b01);
    chk("lit_t3_done_err1", done_err, 1);
    respond(8'd9, 8'h00, 9'h1FB);   // never issued, credits -5
    chk("lit_t3_unexp", unexpected_rsp, 1);
    chk("lit_t3_no_done", {rd_done, wr_done}, 0);
    chk("lit_t3_clamp_low", credits, 0);

    // Reset with three tags outstanding.
    reset = 1;
    #1;
    chk("lit_t4_idle", idle, 1);
    chk("lit_t4_state", {credits, unexpected_rsp, cmd_valid}, 0);
    tick(); reset = 0; tick();
    respond(8'd0, 8'h00, 9'd0);
    chk("lit_t4_forgotten", unexpected_rsp, 1);
    chk("lit_t4_forgotten_nodone", {rd_done, wr_done}, 0);
    room = 8'd4; job_start = 1; tick(); job_start = 0;
    chk("lit_t4_credits", credits, 4);
    chk("lit_t4_unexp_clr", unexpected_rsp, 0);

    // A response during job_start is dropped; credits saturate at 255.
    room = 8'd250; job_start = 1;
    respond(8'd9, 8'h00, 9'd100);
    job_start = 0;
    chk("lit_t5_dropped_credits", credits, 250);
    chk("lit_t5_dropped_unexp", unexpected_rsp, 0);
    respond(8'd9, 8'h00, 9'd100);
    chk("lit_t5_clamp_high", credits, 255);
    chk("lit_t5_unexp", unexpected_rsp, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
